// File: rtl/bus_dual_arbiter_if.sv
// ----------------------------------------------------------------------------
// bus_dual_arbiter_if
//
// Signal bundle between the two bus initiators, the split-capable target and
// the dual-master arbiter.
//
//   m0_req / m1_req   level requests from the initiator ports
//   m0_grant/m1_grant registered grants back to the initiator ports
//   s_ack             one-cycle pulse: current transaction complete
//   s_split           one-cycle pulse: target split the current transaction
//   split_ready       one-cycle pulse: split target ready to return data
//   split_id          master index that split_ready refers to
//   bus_owner         index of the granted master (holds last value when idle)
//   bus_busy          high while any grant is asserted
//   split_pending     per-master parked-in-split mask
//   timeout_err       one-cycle pulse on watchdog release
//
// Modports:
//   slave  - the arbiter side (consumes requests/strobes, drives grants)
//   master - the initiator/target side (drives requests/strobes)
// ----------------------------------------------------------------------------
interface bus_dual_arbiter_if;
    logic       m0_req;
    logic       m1_req;
    logic       m0_grant;
    logic       m1_grant;
    logic       s_ack;
    logic       s_split;
    logic       split_ready;
    logic       split_id;
    logic       bus_owner;
    logic       bus_busy;
    logic [1:0] split_pending;
    logic       timeout_err;

    modport slave (
        input  m0_req, m1_req, s_ack, s_split, split_ready, split_id,
        output m0_grant, m1_grant, bus_owner, bus_busy, split_pending, timeout_err
    );

    modport master (
        output m0_req, m1_req, s_ack, s_split, split_ready, split_id,
        input  m0_grant, m1_grant, bus_owner, bus_busy, split_pending, timeout_err
    );
endinterface

// File: rtl/bus_dual_arbiter.sv
// ----------------------------------------------------------------------------
// bus_dual_arbiter
//
// Two-master arbiter with split-transaction support. Grants the bus to one
// master at a time, holds the grant for the whole transaction, parks a master
// whose target split the transaction and re-grants it ahead of new requests
// once the target reports readiness. A watchdog reclaims the bus from an
// owner that never sees s_ack/s_split.
//
// Parameters:
//   TIMEOUT_CYCLES  max grant cycles without s_ack/s_split (2..1023)
//
// Ports:
//   clk   bus clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   bus_dual_arbiter_if.slave (requests, grants, target strobes, status)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin between two eligible masters
//                       undefined -> fixed priority, master 0 always wins
// ----------------------------------------------------------------------------
module bus_dual_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    bus_dual_arbiter_if.slave   bus
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            owner_q, owner_d;
    logic            resume_grant_q, resume_grant_d;  // current grant is a split resume
    logic [WD_W-1:0] wd_q, wd_d;
    logic [1:0]      split_pending_q, split_pending_d;
    logic [1:0]      resume_pending_q, resume_pending_d;
    logic            timeout_err_q, timeout_err_d;
    logic            release_bus;

    logic [1:0]      req;
    logic [1:0]      eligible;
    logic            take_resume;
    logic            take_new;
    logic            resume_sel;
    logic            new_winner;

    assign req         = {bus.m1_req, bus.m0_req};
    // A parked master cannot compete with a fresh request until it is resumed.
    assign eligible    = req & ~split_pending_q;
    assign take_resume = (state_q == IDLE) && (resume_pending_q != 2'b00);
    assign take_new    = (state_q == IDLE) && !take_resume && (eligible != 2'b00);
    // Lowest-index resume bit wins.
    assign resume_sel  = ~resume_pending_q[0];

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner_q;

    // On a tie the master that lost the previous new-request grant wins;
    // a single eligible master simply wins.
    assign new_winner = (eligible == 2'b11) ? ~last_winner_q : eligible[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_q <= 1'b1;
        end else if (take_new) begin
            last_winner_q <= new_winner;
        end
    end
`else
    // Master 0 wins whenever it is eligible.
    assign new_winner = ~eligible[0];
`endif

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case/if tree can leave a value unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        owner_d          = owner_q;
        resume_grant_d   = resume_grant_q;
        wd_d             = '0;
        split_pending_d  = split_pending_q;
        resume_pending_d = resume_pending_q;
        timeout_err_d    = 1'b0;
        release_bus      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (take_resume) begin
                    grant_d                      = resume_sel ? 2'b10 : 2'b01;
                    owner_d                      = resume_sel;
                    resume_grant_d               = 1'b1;
                    resume_pending_d[resume_sel] = 1'b0;
                    state_d                      = GRANT;
                end else if (take_new) begin
                    grant_d        = new_winner ? 2'b10 : 2'b01;
                    owner_d        = new_winner;
                    resume_grant_d = 1'b0;
                    state_d        = GRANT;
                end
            end

            GRANT: begin
                if (bus.s_ack) begin
                    // Ack beats a simultaneous split: no split is recorded.
                    split_pending_d[owner_q] = 1'b0;
                    release_bus              = 1'b1;
                end else if (bus.s_split) begin
                    split_pending_d[owner_q] = 1'b1;
                    release_bus              = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    timeout_err_d            = 1'b1;
                    split_pending_d[owner_q] = 1'b0;
                    release_bus              = 1'b1;
                end else if (!req[owner_q] && !resume_grant_q) begin
                    // A resumed master keeps the bus regardless of its req
                    // until the target acks, splits again or times out.
                    release_bus = 1'b1;
                end else begin
                    // Release happens at the terminal count, so this never wraps.
                    wd_d = wd_q + WD_W'(1);
                end

                if (release_bus) begin
                    grant_d = 2'b00;
                    state_d = RELEASE;
                end
            end

            RELEASE: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end

            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase

        // Readiness is only meaningful for a master actually parked in split;
        // accepted in any state and serviced at the next IDLE decision.
        if (bus.split_ready && split_pending_q[bus.split_id]) begin
            resume_pending_d[bus.split_id] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            grant_q          <= 2'b00;
            owner_q          <= 1'b0;
            resume_grant_q   <= 1'b0;
            wd_q             <= '0;
            split_pending_q  <= 2'b00;
            resume_pending_q <= 2'b00;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            owner_q          <= owner_d;
            resume_grant_q   <= resume_grant_d;
            wd_q             <= wd_d;
            split_pending_q  <= split_pending_d;
            resume_pending_q <= resume_pending_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign bus.m0_grant      = grant_q[0];
    assign bus.m1_grant      = grant_q[1];
    assign bus.bus_owner     = owner_q;
    assign bus.bus_busy      = |grant_q;
    assign bus.split_pending = split_pending_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: doc/bus_dual_arbiter.md
# bus_dual_arbiter

Two-master arbiter with split-transaction support for the dual-master serial system bus. Sits between the initiator ports' arbiter request/grant lines and the target-side `s_ack`/`s_split` strobes. It grants the bus to one master at a time, holds grant for the whole transaction, and parks a master whose target issued a split. When the target signals readiness it re-grants that master ahead of new requests. A watchdog reclaims the bus from a stuck owner.

## Interface
- `TIMEOUT_CYCLES`, 64: max grant cycles without `s_ack`/`s_split` before forced release; legal range 2..1023.
- `clk` input 1: bus clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `m0_req` input 1: master 0 request, level; driven from initiator port `arbiter_req`.
- `m1_req` input 1: master 1 request, level.
- `m0_grant` output 1: master 0 grant, registered; feeds initiator port `arbiter_grant`.
- `m1_grant` output 1: master 1 grant, registered.
- `s_ack` input 1: one-cycle pulse, current transaction complete.
- `s_split` input 1: one-cycle pulse, target split the current transaction.
- `split_ready` input 1: one-cycle pulse, split target ready to return data.
- `split_id` input 1: master index that `split_ready` refers to.
- `bus_owner` output 1: index of the granted master; holds last value when idle.
- `bus_busy` output 1: high while any grant is asserted.
- `split_pending` output 2: per-master parked-in-split mask.
- `timeout_err` output 1: one-cycle pulse on watchdog release.

## Operation
- Reset values: all grants 0, `bus_busy` 0, `bus_owner` 0, `split_pending` 2'b00, `timeout_err` 0, `resume_pending` 2'b00, watchdog 0, last-winner 1 (so master 0 wins the first round-robin contest). FSM enters IDLE.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE, first matching rule applies:
  1. If `resume_pending` is non-zero, grant the lowest-index set bit, ignoring that master's `req`, and clear its resume bit. Go to GRANT.
  2. Otherwise, eligible requesters are those with `req` high and `split_pending` clear. If any are eligible, select a winner by the priority rule in Configuration and go to GRANT.
  3. Otherwise, stay in IDLE.
- GRANT: grant is held, and the watchdog increments each cycle. Exit conditions, in priority order:
  1. `s_ack`: clear `split_pending[owner]`. Go to RELEASE.
  2. `s_split`: set `split_pending[owner]`. Go to RELEASE.
  3. Watchdog equals `TIMEOUT_CYCLES-1`: pulse `timeout_err` and clear `split_pending[owner]`. Go to RELEASE.
  4. `req[owner]` low and the grant is not a split resume: go to RELEASE.
- RELEASE: grants low, watchdog cleared. This is a one-cycle bus turnaround; always returns to IDLE.
- `split_ready` handling:
  - Sets `resume_pending[split_id]` only if `split_pending[split_id]` is set; otherwise it is ignored.
  - Accepted in any state, including while the other master owns the bus. It is serviced at the next IDLE.
- `s_ack` and `s_split` in the same cycle: `s_ack` wins and no split is recorded.
- `s_ack`, `s_split`, `split_ready` outside a matching condition (e.g. in IDLE): no effect, except `split_ready` as above.
- Grants are one-hot or zero at all times.
- Watchdog is a `$clog2(TIMEOUT_CYCLES)`-bit counter; it never wraps, because release occurs at the terminal count.

## Timing
- Request to grant: `req` sampled high in IDLE at edge N gives grant high after edge N, so the grant is visible in cycle N+1. This is one-cycle latency.
- Back-to-back: minimum two cycles from the exit edge to the next grant (RELEASE, then IDLE decision).
- `s_ack` or `s_split` sampled at edge N: grant low after edge N.
- `split_pending` updates on the same edge that the split or ack is sampled.
- Timeout: grant drops exactly `TIMEOUT_CYCLES` cycles after it rose, provided no ack or split occurs. `timeout_err` is high in the first grant-low cycle.
- Reset asserted mid-transaction: grants drop asynchronously, and all pending split and resume state is discarded.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both masters are eligible, the master that did not win the previous non-resume grant wins. The last-winner register updates only on new-request grants.
- Not defined: fixed priority; master 0 always beats master 1. The last-winner register is not implemented.
- Resume priority (rule 1) is identical in both builds.

## Test plan
- Single request: `m0_req`=1 from cycle 3, `s_ack` pulse at cycle 8 → `m0_grant` high cycles 4..8, low from cycle 9, `bus_busy` mirrors the grant, `bus_owner`=0.
- Contention: `m0_req`=`m1_req`=1 continuously, `s_ack` every grant after 3 cycles → fixed build: master 0 wins every grant. Round-robin build: grant order is 0,1,0,1, with two idle cycles between grants.
- Split: m0 granted, `s_split` → `split_pending`=2'b01 and m1 granted 2 cycles later. `split_ready` with `split_id`=0 during m1's grant → after m1's `s_ack`, m0 is re-granted before pending m1 requests, then m0's `s_ack` clears `split_pending` to 2'b00.
- Timeout: `TIMEOUT_CYCLES`=8, `m1_req` held high, no ack → `m1_grant` high for exactly 8 cycles, then a single `timeout_err` pulse.
- Corner cases:
  - `s_ack` and `s_split` asserted together → `split_pending` stays 2'b00.
  - `split_ready` for a master with no split pending → ignored.
  - `rst` pulse mid-grant → all outputs return to reset values asynchronously.
